// File: rtl/ce_seq_pkg.sv
// Shared types and helpers for the reset / clock-enable sequencer.
// State encoding is fixed so state_o is stable for debug tooling.
package ce_seq_pkg;

  localparam logic [2:0] ENC_RESET = 3'd0;
  localparam logic [2:0] ENC_HOLD  = 3'd1;
  localparam logic [2:0] ENC_GUARD = 3'd2;
  localparam logic [2:0] ENC_IDLE  = 3'd3;
  localparam logic [2:0] ENC_RUN   = 3'd4;
  localparam logic [2:0] ENC_DRAIN = 3'd5;

  typedef enum logic [2:0] {
    S_RESET = ENC_RESET,
    S_HOLD  = ENC_HOLD,
    S_GUARD = ENC_GUARD,
    S_IDLE  = ENC_IDLE,
    S_RUN   = ENC_RUN,
    S_DRAIN = ENC_DRAIN
  } seq_state_t;

  // Counter must hold the largest dwell time loaded into it.
  function automatic int cnt_width(input int hold, input int guard, input int drain);
    int m;
    m = hold;
    if (guard > m) m = guard;
    if (drain > m) m = drain;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ce_seq_timer.sv
// Loadable down-counter timing state dwell. expire flags the last cycle
// of a loaded interval; the count parks at zero instead of wrapping.
module ce_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)             cnt <= '0;
    else if (load)        cnt <= value;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/ce_rst_sequencer.sv
// Sequences datapath reset and clock enable so ce never overlaps reset.
// Define CE_SEQ_ASSERT_EN to embed protocol assertions.
module ce_rst_sequencer
  import ce_seq_pkg::*;
#(
  parameter int HOLD_CYC  = 4,
  parameter int GUARD_CYC = 2,
  parameter int DRAIN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_req,
  input  logic       stall,
  input  logic       soft_rst_req,
  output logic       rst_out,
  output logic       ce,
  output logic       ready,
  output logic [2:0] state_o
);

  localparam int CW = cnt_width(HOLD_CYC, GUARD_CYC, DRAIN_CYC);

  seq_state_t    state, nxt;
  logic          load, expire;
  logic [CW-1:0] load_val;

  always_comb begin
    nxt = state;
    unique case (state)
      S_RESET: nxt = S_HOLD;
      S_HOLD:  if (expire) nxt = S_GUARD;
      S_GUARD: begin
        if (soft_rst_req) nxt = S_DRAIN;
        else if (expire)  nxt = S_IDLE;
      end
      S_IDLE: begin
        if (soft_rst_req) nxt = S_DRAIN;
        else if (run_req) nxt = S_RUN;
      end
      S_RUN: begin
        if (soft_rst_req)  nxt = S_DRAIN;
        else if (!run_req) nxt = S_IDLE;
      end
      S_DRAIN: if (expire) nxt = S_HOLD;
      default: nxt = S_RESET;
    endcase
  end

  // Timer reloads on every state change; states without a dwell load zero.
  always_comb begin
    load     = (nxt != state);
    load_val = '0;
    case (nxt)
      S_HOLD:  load_val = CW'(HOLD_CYC);
      S_GUARD: load_val = CW'(GUARD_CYC);
      S_DRAIN: load_val = CW'(DRAIN_CYC);
      default: load_val = '0;
    endcase
  end

  ce_seq_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .value  (load_val),
    .expire (expire)
  );

  // Outputs decode the next state so they are registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_RESET;
      rst_out <= 1'b1;
      ce      <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state   <= nxt;
      rst_out <= (nxt == S_RESET) || (nxt == S_HOLD);
      ce      <= (nxt == S_RUN) && !stall;
      ready   <= (nxt == S_IDLE) || (nxt == S_RUN);
    end
  end

  assign state_o = state;

`ifdef CE_SEQ_ASSERT_EN
  a1_no_ce_in_reset: assert property (@(posedge clk) disable iff (!rst)
    rst_out |-> !ce)
    $info("A1 ok"); else $error("A1 rst_out with ce");

  a2_guard_after_release: assert property (@(posedge clk) disable iff (!rst)
    $fell(rst_out) |-> !ce [*GUARD_CYC])
    $info("A2 ok"); else $error("A2 ce inside guard window");

  a3_hold_until_guard: assert property (@(posedge clk) disable iff (!rst)
    (state == S_HOLD) |-> (rst_out s_until (state == S_GUARD)))
    $info("A3 ok"); else $error("A3 rst_out dropped during HOLD");
`endif

endmodule
